// File: rtl/mem_wb_stage_pkg.sv
// Definitions shared by the ID/EX/MEM/WB stages: load opcodes, stall vector
// bit positions and the load-extension helper.
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } ldop_e;

  localparam int unsigned STALL_IF  = 0;
  localparam int unsigned STALL_ID  = 1;
  localparam int unsigned STALL_EX  = 2;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Extends a 16-bit quantity to 32 bits, sign- or zero-filled.
  function automatic logic [31:0] ext16(input logic [15:0] val, input logic sign_ext);
    return {{16{sign_ext & val[15]}}, val};
  endfunction

  // Extends an 8-bit quantity to 32 bits, sign- or zero-filled.
  function automatic logic [31:0] ext8(input logic [7:0] val, input logic sign_ext);
    return {{24{sign_ext & val[7]}}, val};
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: selects and extends the big-endian bytes of the read word,
// merging with the old rt value for LWL/LWR.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ldop_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and half-word selection; offset 0 is the most significant byte.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[31:24];
      2'd1:    byte_s = rdata_i[23:16];
      2'd2:    byte_s = rdata_i[15:8];
      2'd3:    byte_s = rdata_i[7:0];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[15:0];
    end else begin
      half_s = rdata_i[31:16];
    end
  end

  // Result decode; reserved codes pass the ALU result through.
  always_comb begin
    wdata_o = rt_i;
    case (ldop_i)
      LD_LB:   wdata_o = ext8(byte_s, 1'b1);
      LD_LBU:  wdata_o = ext8(byte_s, 1'b0);
      LD_LH:   wdata_o = ext16(half_s, 1'b1);
      LD_LHU:  wdata_o = ext16(half_s, 1'b0);
      LD_LW:   wdata_o = rdata_i;
      LD_LWL: begin
        case (addr_lo_i)
          2'd0:    wdata_o = rdata_i;
          2'd1:    wdata_o = {rdata_i[23:0], rt_i[7:0]};
          2'd2:    wdata_o = {rdata_i[15:0], rt_i[15:0]};
          2'd3:    wdata_o = {rdata_i[7:0], rt_i[23:0]};
          default: wdata_o = rdata_i;
        endcase
      end
      LD_LWR: begin
        case (addr_lo_i)
          2'd0:    wdata_o = {rt_i[31:8], rdata_i[31:24]};
          2'd1:    wdata_o = {rt_i[31:16], rdata_i[31:16]};
          2'd2:    wdata_o = {rt_i[31:24], rdata_i[31:8]};
          2'd3:    wdata_o = rdata_i;
          default: wdata_o = rdata_i;
        endcase
      end
      default: wdata_o = rt_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: captures MEM results, aligns the synchronous
// data-memory read in the WB cycle and drives the regfile and HI/LO ports.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_ldop,
  input  logic [1:0]        mem_addr_lo,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo
);

  logic              wreg_q, wreg_d;
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        ldop_q, ldop_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              whilo_q, whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Earlier-stage stall bits are carried in the shared vector but not used here.
  logic unused_stall_s;
  assign unused_stall_s = ^stall[3:0];

  // Next-state: flush beats everything, a MEM-only stall drains a bubble into WB.
  always_comb begin
    wreg_d    = wreg_q;
    wd_d      = wd_q;
    wdata_d   = wdata_q;
    ldop_d    = ldop_q;
    addr_lo_d = addr_lo_q;
    whilo_d   = whilo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (flush || (stall[STALL_MEM] && !stall[STALL_WB])) begin
      wreg_d    = 1'b0;
      wd_d      = '0;
      wdata_d   = '0;
      ldop_d    = LD_NONE;
      addr_lo_d = 2'd0;
      whilo_d   = 1'b0;
      hi_d      = '0;
      lo_d      = '0;
    end else if (!stall[STALL_MEM]) begin
      wreg_d    = mem_wreg;
      wd_d      = mem_wd;
      wdata_d   = mem_wdata;
      ldop_d    = mem_ldop;
      addr_lo_d = mem_addr_lo;
      whilo_d   = mem_whilo;
      hi_d      = mem_hi;
      lo_d      = mem_lo;
    end else begin
      wreg_d    = wreg_q;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wreg_q    <= 1'b0;
      wd_q      <= '0;
      wdata_q   <= '0;
      ldop_q    <= LD_NONE;
      addr_lo_q <= 2'd0;
      whilo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      wreg_q    <= wreg_d;
      wd_q      <= wd_d;
      wdata_q   <= wdata_d;
      ldop_q    <= ldop_d;
      addr_lo_q <= addr_lo_d;
      whilo_q   <= whilo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  mem_wb_stage_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .ldop_i   (ldop_q),
    .addr_lo_i(addr_lo_q),
    .rt_i     (wdata_q),
    .rdata_i  (dmem_rdata),
    .wdata_o  (wb_wdata)
  );

  assign wb_we    = wreg_q;
  assign wb_waddr = wd_q;
  assign wb_whilo = whilo_q;
  assign wb_hi    = hi_q;
  assign wb_lo    = lo_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ldop;
  logic [1:0]  mem_addr_lo;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of what the stage holds after the most recent edge.
  logic        m_wreg;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata;
  logic [2:0]  m_ldop;
  logic [1:0]  m_off;
  logic        m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_ldop(mem_ldop), .mem_addr_lo(mem_addr_lo), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected load result from shift/mask arithmetic on the big-endian word.
  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] rt, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [63:0] w;
    int          n;
    b = 8'(d >> (8 * (3 - int'(off))));
    h = 16'(d >> (16 * (1 - int'(off[1]))));
    case (op)
      3'd1: return b[7] ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
      3'd2: return 32'(b);
      3'd3: return h[15] ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
      3'd4: return 32'(h);
      3'd5: return d;
      3'd6: begin
        n = 8 * int'(off);
        w = ({32'h0, d} << n) | ({32'h0, rt} & ((64'h1 << n) - 64'h1));
        return w[31:0];
      end
      3'd7: begin
        n = 8 * (int'(off) + 1);
        w = ({32'h0, rt} & ~((64'h1 << n) - 64'h1)) | ({32'h0, d} >> (32 - n));
        return w[31:0];
      end
      default: return rt;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output against it on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst || flush || (stall[4] && !stall[5])) begin
      m_wreg = 1'b0; m_wd = 5'd0; m_wdata = 32'd0; m_ldop = 3'd0;
      m_off = 2'd0; m_whilo = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (!stall[4]) begin
      m_wreg = mem_wreg; m_wd = mem_wd; m_wdata = mem_wdata; m_ldop = mem_ldop;
      m_off = mem_addr_lo; m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo;
    end
    @(negedge clk);
    chk("model_we",    32'(wb_we),    32'(m_wreg));
    chk("model_waddr", 32'(wb_waddr), 32'(m_wd));
    chk("model_wdata", wb_wdata,      exp_wdata(m_ldop, m_off, m_wdata, dmem_rdata));
    chk("model_whilo", 32'(wb_whilo), 32'(m_whilo));
    chk("model_hi",    wb_hi,         m_hi);
    chk("model_lo",    wb_lo,         m_lo);
    #1;
  endtask

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [1:0] off, input logic [31:0] rd);
    mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata; mem_ldop = op;
    mem_addr_lo = off; dmem_rdata = rd;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] exp;
  } load_case_t;

  load_case_t lc[9];

  initial begin
    lc[0] = '{3'd1, 2'd0, 32'h0, 32'h80FF_7F01, 32'hFFFF_FF80};
    lc[1] = '{3'd2, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0000_00FF};
    lc[2] = '{3'd1, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0000_007F};
    lc[3] = '{3'd3, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0000_7F01};
    lc[4] = '{3'd4, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0000_80FF};
    lc[5] = '{3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD};
    lc[6] = '{3'd7, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122};
    lc[7] = '{3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
    lc[8] = '{3'd7, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};

    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    mem_whilo = 1'b1; mem_hi = 32'h5555_5555; mem_lo = 32'h6666_6666;
    drive(1'b1, 5'd7, 32'hCAFE_F00D, 3'd0, 2'd3, 32'h9999_9999);
    tick();
    tick();
    chk("reset_we", 32'(wb_we), 32'd0);
    chk("reset_wdata", wb_wdata, 32'd0);
    chk("reset_hi", wb_hi, 32'd0);

    rst = 1'b0; mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
    drive(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'h0);
    tick();
    chk("first_we", 32'(wb_we), 32'd1);
    chk("first_waddr", 32'(wb_waddr), 32'd5);
    chk("first_wdata", wb_wdata, 32'h1234_5678);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'(i + 1), lc[i].rt, lc[i].op, lc[i].off, lc[i].rd);
      tick();
      chk($sformatf("load_case_%0d", i), wb_wdata, lc[i].exp);
    end

    drive(1'b1, 5'd9, 32'h0BAD_0001, 3'd0, 2'd0, 32'h0);
    tick();
    stall = 6'b011111;
    drive(1'b1, 5'd10, 32'h0BAD_0002, 3'd0, 2'd0, 32'h0);
    tick();
    chk("bubble_we", 32'(wb_we), 32'd0);
    chk("bubble_wdata", wb_wdata, 32'd0);
    stall = 6'b000000;
    tick();
    stall = 6'b111111;
    drive(1'b1, 5'd11, 32'h0BAD_0003, 3'd0, 2'd0, 32'h0);
    tick();
    tick();
    chk("hold_we", 32'(wb_we), 32'd1);
    chk("hold_waddr", 32'(wb_waddr), 32'd10);
    chk("hold_wdata", wb_wdata, 32'h0BAD_0002);
    stall = 6'b000000;
    tick();
    chk("resume_waddr", 32'(wb_waddr), 32'd11);

    stall = 6'b111111; flush = 1'b1; mem_whilo = 1'b1;
    tick();
    chk("flush_we", 32'(wb_we), 32'd0);
    chk("flush_whilo", 32'(wb_whilo), 32'd0);
    flush = 1'b0; stall = 6'b000000;

    mem_whilo = 1'b1; mem_hi = 32'hDEAD_BEEF; mem_lo = 32'h0000_0001;
    drive(1'b0, 5'd3, 32'h7777_7777, 3'd0, 2'd0, 32'h0);
    tick();
    chk("hilo_whilo", 32'(wb_whilo), 32'd1);
    chk("hilo_hi", wb_hi, 32'hDEAD_BEEF);
    chk("hilo_lo", wb_lo, 32'h0000_0001);
    chk("hilo_we", 32'(wb_we), 32'd0);

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0:       stall = 6'b011111;
        1:       stall = 6'b111111;
        2:       stall = 6'($urandom);
        default: stall = 6'b000000;
      endcase
      mem_whilo = 1'($urandom);
      mem_hi    = $urandom;
      mem_lo    = $urandom;
      drive(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
